video_mnist_frame_ctrl: RTL and testbench

- Frame-level controller placed in front of the MNIST CNN detection datapath on its AXI4-Stream input.
- Admits or drops whole frames according to an enable bit and a programmable skip ratio.
- Applies binarization parameters (threshold, invert) atomically at frame boundaries from Wishbone shadow registers.
- Inserts one register stage so that new parameters and the first pixel of the admitted frame appear downstream in the same cycle.

---
 rtl/video_mnist_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_video_mnist_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_frame_ctrl.sv
// Frame admission/skip controller with frame-atomic binarization parameters
// for the MNIST CNN AXI4-Stream input, configured over a zero-wait Wishbone slave.
module video_mnist_frame_ctrl #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned TUSER_WIDTH     = 1,
  parameter int unsigned SKIP_WIDTH      = 8,
  parameter int unsigned WB_ADR_WIDTH    = 8,
  parameter int unsigned WB_DAT_WIDTH    = 32,
  parameter int unsigned WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
  parameter logic [31:0] CORE_ID         = 32'h527a_2f10,
  parameter logic        INIT_CTL_ENABLE = 1'b0,
  parameter int unsigned INIT_PARAM_TH   = 127,
  parameter logic        INIT_PARAM_INV  = 1'b0,
  parameter int unsigned INIT_PARAM_SKIP = 0
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,

  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                    s_axi4s_tvalid,
  output logic                    s_axi4s_tready,

  output logic [TUSER_WIDTH-1:0]  m_axi4s_tuser,
  output logic                    m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                    m_axi4s_tvalid,
  input  logic                    m_axi4s_tready,

  output logic [DATA_WIDTH-1:0]   param_th,
  output logic                    param_inv,
  output logic                    frame_start
);

  localparam logic [WB_ADR_WIDTH-1:0] ADR_ID      = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS  = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FCOUNT  = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SKIP    = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH      = WB_ADR_WIDTH'(5);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INV     = WB_ADR_WIDTH'(6);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SKIP} state_e;

  state_e                  state_q,       state_d;
  logic [SKIP_WIDTH-1:0]   skip_cnt_q,    skip_cnt_d;
  logic [SKIP_WIDTH-1:0]   skip_q,        skip_d;
  logic                    enable_q,      enable_d;
  logic                    update_req_q,  update_req_d;
  logic [DATA_WIDTH-1:0]   shd_th_q,      shd_th_d;
  logic                    shd_inv_q,     shd_inv_d;
  logic [DATA_WIDTH-1:0]   param_th_q,    param_th_d;
  logic                    param_inv_q,   param_inv_d;
  logic [31:0]             frame_cnt_q,   frame_cnt_d;
  logic                    m_tvalid_q,    m_tvalid_d;
  logic [TUSER_WIDTH-1:0]  m_tuser_q,     m_tuser_d;
  logic                    m_tlast_q,     m_tlast_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q,     m_tdata_d;
  logic                    frame_start_q, frame_start_d;

  logic s_ready_c, beat_c, sof_c, admit_c, apply_c;
  logic wb_wr_c;

  // Byte-lane merge of Wishbone write data into the current register image.
  function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
    input logic [WB_DAT_WIDTH-1:0] cur,
    input logic [WB_DAT_WIDTH-1:0] dat,
    input logic [WB_SEL_WIDTH-1:0] sel
  );
    logic [WB_DAT_WIDTH-1:0] r;
    r = cur;
    for (int b = 0; b < int'(WB_SEL_WIDTH); b++) begin
      if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    end
    return r;
  endfunction

  // Frame admission state machine, output register slice and parameter apply.
  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    param_th_d    = param_th_q;
    param_inv_d   = param_inv_q;
    frame_cnt_d   = frame_cnt_q;
    m_tvalid_d    = m_tvalid_q;
    m_tuser_d     = m_tuser_q;
    m_tlast_d     = m_tlast_q;
    m_tdata_d     = m_tdata_q;
    frame_start_d = 1'b0;
    admit_c       = 1'b0;
    apply_c       = 1'b0;

    s_ready_c = !m_tvalid_q || m_axi4s_tready;
    beat_c    = s_axi4s_tvalid && s_ready_c;
    sof_c     = beat_c && s_axi4s_tuser[0];

    case (state_q)
      ST_IDLE: begin
        if (sof_c && enable_q) begin
          admit_c    = 1'b1;
          state_d    = ST_RUN;
          skip_cnt_d = skip_q;
        end
      end
      ST_RUN: begin
        if (sof_c) begin
          if (!enable_q)             state_d = ST_IDLE;
          else if (skip_q == '0)     admit_c = 1'b1;
          else                       state_d = ST_SKIP;
        end else begin
          admit_c = beat_c;
        end
      end
      ST_SKIP: begin
        if (sof_c) begin
          if (!enable_q) begin
            state_d = ST_IDLE;
          end else if (skip_cnt_q <= SKIP_WIDTH'(1)) begin
            admit_c    = 1'b1;
            state_d    = ST_RUN;
            skip_cnt_d = skip_q;
          end else begin
            skip_cnt_d = skip_cnt_q - SKIP_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Single-entry slice: load on admitted beat, otherwise drain when taken.
    if (admit_c) begin
      m_tvalid_d = 1'b1;
      m_tuser_d  = s_axi4s_tuser;
      m_tlast_d  = s_axi4s_tlast;
      m_tdata_d  = s_axi4s_tdata;
    end else if (m_axi4s_tready) begin
      m_tvalid_d = 1'b0;
    end

    if (admit_c && s_axi4s_tuser[0]) begin
      frame_start_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 32'd1;
      if (update_req_q) begin
        apply_c     = 1'b1;
        param_th_d  = shd_th_q;
        param_inv_d = shd_inv_q;
      end
    end
  end

  // Wishbone register writes; a same-cycle request set wins over apply-clear.
  always_comb begin
    enable_d     = enable_q;
    update_req_d = update_req_q;
    skip_d       = skip_q;
    shd_th_d     = shd_th_q;
    shd_inv_d    = shd_inv_q;
    wb_wr_c      = s_wb_stb_i && s_wb_we_i;

    if (apply_c) update_req_d = 1'b0;

    if (wb_wr_c) begin
      case (s_wb_adr_i)
        ADR_CONTROL: begin
          enable_d = 1'(wb_merge(WB_DAT_WIDTH'(enable_q), s_wb_dat_i, s_wb_sel_i));
          if (s_wb_sel_i[0] && s_wb_dat_i[1]) update_req_d = 1'b1;
        end
        ADR_SKIP: skip_d    = SKIP_WIDTH'(wb_merge(WB_DAT_WIDTH'(skip_q), s_wb_dat_i, s_wb_sel_i));
        ADR_TH:   shd_th_d  = DATA_WIDTH'(wb_merge(WB_DAT_WIDTH'(shd_th_q), s_wb_dat_i, s_wb_sel_i));
        ADR_INV:  shd_inv_d = 1'(wb_merge(WB_DAT_WIDTH'(shd_inv_q), s_wb_dat_i, s_wb_sel_i));
        default: ;
      endcase
    end
  end

  // Zero-wait-state read mux; unmapped addresses read as zero.
  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_ID:      s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL: s_wb_dat_o = WB_DAT_WIDTH'({update_req_q, enable_q});
      ADR_STATUS:  s_wb_dat_o = WB_DAT_WIDTH'({update_req_q, state_q != ST_IDLE});
      ADR_FCOUNT:  s_wb_dat_o = WB_DAT_WIDTH'(frame_cnt_q);
      ADR_SKIP:    s_wb_dat_o = WB_DAT_WIDTH'(skip_q);
      ADR_TH:      s_wb_dat_o = WB_DAT_WIDTH'(shd_th_q);
      ADR_INV:     s_wb_dat_o = WB_DAT_WIDTH'(shd_inv_q);
      default:     s_wb_dat_o = '0;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      skip_cnt_q    <= '0;
      skip_q        <= SKIP_WIDTH'(INIT_PARAM_SKIP);
      enable_q      <= INIT_CTL_ENABLE;
      update_req_q  <= 1'b0;
      shd_th_q      <= DATA_WIDTH'(INIT_PARAM_TH);
      shd_inv_q     <= INIT_PARAM_INV;
      param_th_q    <= DATA_WIDTH'(INIT_PARAM_TH);
      param_inv_q   <= INIT_PARAM_INV;
      frame_cnt_q   <= '0;
      m_tvalid_q    <= 1'b0;
      m_tuser_q     <= '0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      skip_q        <= skip_d;
      enable_q      <= enable_d;
      update_req_q  <= update_req_d;
      shd_th_q      <= shd_th_d;
      shd_inv_q     <= shd_inv_d;
      param_th_q    <= param_th_d;
      param_inv_q   <= param_inv_d;
      frame_cnt_q   <= frame_cnt_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tuser_q     <= m_tuser_d;
      m_tlast_q     <= m_tlast_d;
      m_tdata_q     <= m_tdata_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign s_axi4s_tready = s_ready_c;
  assign s_wb_ack_o     = s_wb_stb_i;
  assign m_axi4s_tvalid = m_tvalid_q;
  assign m_axi4s_tuser  = m_tuser_q;
  assign m_axi4s_tlast  = m_tlast_q;
  assign m_axi4s_tdata  = m_tdata_q;
  assign param_th       = param_th_q;
  assign param_inv      = param_inv_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_video_mnist_frame_ctrl.sv
// Directed self-checking bench for video_mnist_frame_ctrl.
module tb_video_mnist_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic [0:0]  s_axi4s_tuser;
  logic        s_axi4s_tlast;
  logic [7:0]  s_axi4s_tdata;
  logic        s_axi4s_tvalid;
  logic        s_axi4s_tready;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [7:0]  m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready;
  logic [7:0]  param_th;
  logic        param_inv;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  video_mnist_frame_ctrl dut (
    .clk(clk), .reset(reset),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready),
    .param_th(param_th), .param_inv(param_inv), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = 4'hf;
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = '0;
    m_axi4s_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    tick();
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
    s_wb_adr_i = adr; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
    #1;
    dat = s_wb_dat_o;
    s_wb_stb_i = 1'b0;
  endtask

  task automatic drive_beat(input logic u, input logic l, input logic [7:0] d);
    s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'(u); s_axi4s_tlast = l; s_axi4s_tdata = d;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    apply_reset();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0d want 0", m_axi4s_tvalid); end
    n_checks++; if ({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== 10'h0) begin n_fail++; $display("FAIL reset_mdata: got %h want 0", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %0d want 0", frame_start); end
    n_checks++; if (param_th !== 8'h7f) begin n_fail++; $display("FAIL reset_param_th: got %h want 7f", param_th); end
    n_checks++; if (param_inv !== 1'b0) begin n_fail++; $display("FAIL reset_param_inv: got %0d want 0", param_inv); end
    n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %0d want 1", s_axi4s_tready); end
    wb_read(8'd0, rd);
    n_checks++; if (rd !== 32'h527a_2f10) begin n_fail++; $display("FAIL reg_id: got %h want 527a2f10", rd); end
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rd); end
    wb_read(8'd3, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_fcount: got %h want 0", rd); end
    wb_read(8'd5, rd);
    n_checks++; if (rd !== 32'h7f) begin n_fail++; $display("FAIL reset_shadow_th: got %h want 7f", rd); end
    s_wb_adr_i = 8'd7; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
    #1;
    n_checks++; if (s_wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL wb_ack_high: got %0d want 1", s_wb_ack_o); end
    n_checks++; if (s_wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL undef_read: got %h want 0", s_wb_dat_o); end
    s_wb_stb_i = 1'b0;
    #1;
    n_checks++; if (s_wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL wb_ack_low: got %0d want 0", s_wb_ack_o); end
  endtask

  task automatic test_basic_stream();
    logic [31:0] rd;
    int fs_cnt;
    logic u, l;
    logic [7:0] d;
    fs_cnt = 0;
    apply_reset();
    wb_write(8'd1, 32'h1, 4'hf);
    for (int i = 0; i < 16; i++) begin
      u = (i % 8 == 0); l = (i % 4 == 3); d = 8'h10 + 8'(i);
      drive_beat(u, l, d);
      tick();
      n_checks++; if ({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== {1'b1, u, l, d})
        begin n_fail++; $display("FAIL stream_beat%0d: got v%0d u%0d l%0d %h want v1 u%0d l%0d %h", i, m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, u, l, d); end
      n_checks++; if (frame_start !== u) begin n_fail++; $display("FAIL stream_fs%0d: got %0d want %0d", i, frame_start, u); end
      if (frame_start === 1'b1) fs_cnt++;
    end
    s_axi4s_tvalid = 1'b0;
    tick();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0d want 0", m_axi4s_tvalid); end
    n_checks++; if (fs_cnt != 2) begin n_fail++; $display("FAIL stream_fs_count: got %0d want 2", fs_cnt); end
    wb_read(8'd3, rd);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL stream_fcount: got %0d want 2", rd); end
    n_checks++; if (param_th !== 8'h7f) begin n_fail++; $display("FAIL stream_th_stable: got %h want 7f", param_th); end
  endtask

  task automatic test_mid_enable();
    logic u;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        s_axi4s_tvalid = 1'b0;
        wb_write(8'd1, 32'h1, 4'hf);
      end
      drive_beat(i == 0, i % 4 == 3, 8'h30 + 8'(i));
      #1;
      n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL midena_tready%0d: got %0d want 1", i, s_axi4s_tready); end
      tick();
      n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL midena_drop%0d: got %0d want 0", i, m_axi4s_tvalid); end
    end
    for (int i = 0; i < 8; i++) begin
      u = (i == 0);
      drive_beat(u, i % 4 == 3, 8'h50 + 8'(i));
      tick();
      n_checks++; if ({m_axi4s_tvalid, m_axi4s_tdata, frame_start} !== {1'b1, 8'h50 + 8'(i), u})
        begin n_fail++; $display("FAIL midena_pass%0d: got v%0d %h fs%0d want v1 %h fs%0d", i, m_axi4s_tvalid, m_axi4s_tdata, frame_start, 8'h50 + 8'(i), u); end
    end
    s_axi4s_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_skip();
    logic [31:0] rd;
    logic pass;
    logic [7:0] d;
    apply_reset();
    wb_write(8'd4, 32'd2, 4'hf);
    wb_write(8'd1, 32'h1, 4'hf);
    for (int f = 0; f < 6; f++) begin
      pass = (f == 0) || (f == 3);
      for (int p = 0; p < 2; p++) begin
        d = 8'(f * 16 + p);
        drive_beat(p == 0, p == 1, d);
        tick();
        n_checks++; if (m_axi4s_tvalid !== pass) begin n_fail++; $display("FAIL skip_f%0d_p%0d_valid: got %0d want %0d", f, p, m_axi4s_tvalid, pass); end
        if (pass) begin
          n_checks++; if (m_axi4s_tdata !== d) begin n_fail++; $display("FAIL skip_f%0d_p%0d_data: got %h want %h", f, p, m_axi4s_tdata, d); end
        end
      end
    end
    s_axi4s_tvalid = 1'b0;
    tick();
    wb_read(8'd3, rd);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL skip_fcount: got %0d want 2", rd); end
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL skip_status: got %h want 1", rd); end
  endtask

  task automatic test_param_update();
    logic [31:0] rd;
    apply_reset();
    wb_write(8'd5, 32'h40, 4'hf);
    wb_write(8'd6, 32'h1, 4'hf);
    wb_write(8'd5, 32'h0000_5555, 4'b1110);
    wb_write(8'd9, 32'hffff_ffff, 4'hf);
    wb_write(8'd1, 32'h3, 4'hf);
    wb_read(8'd5, rd);
    n_checks++; if (rd !== 32'h40) begin n_fail++; $display("FAIL param_shadow_th: got %h want 40", rd); end
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL param_status_pending: got %h want 2", rd); end
    n_checks++; if ({param_th, param_inv} !== {8'h7f, 1'b0}) begin n_fail++; $display("FAIL param_before: got %h/%0d want 7f/0", param_th, param_inv); end
    drive_beat(1'b1, 1'b0, 8'h01);
    tick();
    n_checks++; if ({param_th, param_inv} !== {8'h40, 1'b1}) begin n_fail++; $display("FAIL param_applied: got %h/%0d want 40/1", param_th, param_inv); end
    n_checks++; if ({m_axi4s_tvalid, m_axi4s_tuser, frame_start} !== 3'b111) begin n_fail++; $display("FAIL param_sof_align: got %b want 111", {m_axi4s_tvalid, m_axi4s_tuser, frame_start}); end
    drive_beat(1'b0, 1'b1, 8'h02);
    tick();
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL param_fs_pulse: got %0d want 0", frame_start); end
    s_axi4s_tvalid = 1'b0;
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL param_status_cleared: got %h want 1", rd); end
    wb_write(8'd5, 32'h10, 4'hf);
    wb_write(8'd1, 32'h3, 4'hf);
    // Apply and a new request in the same cycle: request must survive.
    drive_beat(1'b1, 1'b0, 8'h03);
    s_wb_adr_i = 8'd1; s_wb_dat_i = 32'h3; s_wb_sel_i = 4'hf; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    tick();
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_axi4s_tvalid = 1'b0;
    n_checks++; if (param_th !== 8'h10) begin n_fail++; $display("FAIL param_second_apply: got %h want 10", param_th); end
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL param_req_survives: got %h want 3", rd); end
  endtask

  task automatic test_backpressure();
    int in_idx, out_idx, stall_cnt, cyc;
    in_idx = 0; out_idx = 0; stall_cnt = 0; cyc = 0;
    apply_reset();
    wb_write(8'd1, 32'h1, 4'hf);
    while (out_idx < 8 && cyc < 40) begin
      m_axi4s_tready = !(cyc >= 2 && cyc <= 4);
      s_axi4s_tvalid = (in_idx < 8);
      s_axi4s_tuser  = 1'(in_idx == 0);
      s_axi4s_tlast  = (in_idx % 4 == 3);
      s_axi4s_tdata  = 8'hA0 + 8'(in_idx);
      #1;
      if (!s_axi4s_tready) stall_cnt++;
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        n_checks++; if (m_axi4s_tdata !== 8'hA0 + 8'(out_idx)) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", out_idx, m_axi4s_tdata, 8'hA0 + 8'(out_idx)); end
        out_idx++;
      end
      if (s_axi4s_tvalid && s_axi4s_tready) in_idx++;
      tick();
      cyc++;
    end
    s_axi4s_tvalid = 1'b0;
    m_axi4s_tready = 1'b1;
    n_checks++; if (out_idx != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8 beats within 40 cycles", out_idx); end
    n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL bp_stall: got %0d want 3 cycles of tready=0", stall_cnt); end
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %0d want 0", m_axi4s_tvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    apply_reset();
    wb_write(8'd5, 32'h22, 4'hf);
    wb_write(8'd1, 32'h3, 4'hf);
    drive_beat(1'b1, 1'b0, 8'h61); tick();
    drive_beat(1'b0, 1'b0, 8'h62); tick();
    n_checks++; if ({m_axi4s_tvalid, param_th} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL rmid_pre: got v%0d th %h want v1 th 22", m_axi4s_tvalid, param_th); end
    drive_beat(1'b0, 1'b0, 8'h63);
    m_axi4s_tready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_axi4s_tready = 1'b1;
    n_checks++; if ({m_axi4s_tvalid, param_th, frame_start} !== {1'b0, 8'h7f, 1'b0}) begin n_fail++; $display("FAIL rmid_cleared: got v%0d th %h fs%0d want v0 th 7f fs0", m_axi4s_tvalid, param_th, frame_start); end
    drive_beat(1'b0, 1'b1, 8'h64); tick();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tail_drop: got %0d want 0", m_axi4s_tvalid); end
    drive_beat(1'b1, 1'b0, 8'h65); tick();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_sof_disabled: got %0d want 0", m_axi4s_tvalid); end
    s_axi4s_tvalid = 1'b0;
    wb_read(8'd2, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rmid_status: got %h want 0", rd); end
    wb_write(8'd1, 32'h1, 4'hf);
    drive_beat(1'b0, 1'b0, 8'h66); tick();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_partial_drop: got %0d want 0", m_axi4s_tvalid); end
    drive_beat(1'b1, 1'b0, 8'h67); tick();
    n_checks++; if ({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tdata, frame_start} !== {1'b1, 1'b1, 8'h67, 1'b1})
      begin n_fail++; $display("FAIL rmid_restart: got v%0d u%0d %h fs%0d want v1 u1 67 fs1", m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tdata, frame_start); end
    s_axi4s_tvalid = 1'b0;
    wb_read(8'd3, rd);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL rmid_fcount: got %0d want 1", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_mid_enable();
    test_skip();
    test_param_update();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
